// File: rtl/clock_divider_nch.sv
// Multi-channel clock divider: one square wave and one tick per channel.
// Each channel has its own run enable and a divisor that changes only at a period boundary.
module clock_divider_nch #(
  parameter int CW  = 27,
  parameter int NCH = 2,
  parameter int CHW = 1,
  parameter logic [NCH*CW-1:0] DIV_INIT =
    {27'd100000, 27'd50000000}
) (
  input  logic           clk1,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [CW-1:0]  wr_div,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic           wr_err
);

  logic ch_ok;
  logic div_ok;
  logic wr_ok;
  logic wr_bad;

  assign ch_ok  = 32'(wr_ch) < NCH;
  assign div_ok = wr_div >= CW'(2);
  assign wr_ok  = wr_en && ch_ok && div_ok;
  assign wr_bad = wr_en && !(ch_ok && div_ok);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_bad;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] d;
    logic [CW-1:0] p;
    logic          pv;
    logic          hit;
    logic          last;
    logic          wrap;
    logic          apply;
    logic          tick_r;
    logic          clk_r;

    assign hit   = wr_ok && (32'(wr_ch) == i);
    assign last  = cnt == (d - CW'(1));
    assign wrap  = en[i] && last;
    // A pending divisor lands at a wrap, or at once while the channel idles
    assign apply = pv && (wrap || !en[i]);

    always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
        cnt    <= '0;
        d      <= DIV_INIT[i*CW +: CW];
        p      <= '0;
        pv     <= 1'b0;
        tick_r <= 1'b0;
        clk_r  <= 1'b0;
      end else begin
        tick_r <= wrap;
        clk_r  <= en[i] && (cnt >= (d >> 1));
        if (sync) begin
          cnt <= '0;
          pv  <= 1'b0;
          if (hit) begin
            d <= wr_div;
          end else if (pv) begin
            d <= p;
          end
        end else begin
          if (!en[i] || last) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
          if (apply) begin
            d <= p;
          end
          if (hit) begin
            p  <= wr_div;
            pv <= 1'b1;
          end else if (apply) begin
            pv <= 1'b0;
          end
        end
      end
    end

    assign tick[i]    = tick_r;
    assign clk_out[i] = clk_r;
  end

endmodule

// File: doc/clock_divider_nch.md
# clock_divider_nch

Parametrised multi-channel clock divider for the 24-hour digital clock. It generalises the fixed 1 Hz / 500 Hz divider into NCH independent channels, each of which provides a 50%-duty square wave and a one-cycle enable tick. Each channel has a per-channel enable and a runtime-writable divisor, applied glitch-free at the period boundary. A global sync restarts all channels for phase alignment. It sits between the board oscillator and the timekeeping counter and display multiplexer.

## Interface
- CW, 27: counter and divisor width in bits.
- NCH, 2: number of channels (1..16).
- CHW, 1: width of the channel index, at least clog2(NCH), minimum 1.
- DIV_INIT, {27'd100000, 27'd50000000}: concatenated reset divisors, CW bits per channel, channel 0 in the LSBs. With a 50 MHz clk1, the defaults give channel 0 = 1 Hz and channel 1 = 500 Hz.
- clk1  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  NCH  per-channel run enable.
- sync  input  1  one-cycle pulse that restarts all channels at count 0.
- wr_en  input  1  divisor write strobe.
- wr_ch  input  CHW  target channel of the write.
- wr_div  input  CW  new divisor value D, in clk1 cycles per output period.
- clk_out  output  NCH  square wave per channel, registered.
- tick  output  NCH  one-cycle pulse per output period, registered.
- wr_err  output  1  one-cycle pulse reporting a rejected write, registered.

## Operation
- **Per-channel state:** active divisor D, counter cnt in 0..D-1, pending divisor P, pending flag pv.
- **Reset:** cnt=0, D=DIV_INIT slice, pv=0, clk_out=0, tick=0, wr_err=0.
- **Counting:** while en[i]=1, cnt increments every cycle. At cnt==D-1 it wraps to 0.
  - If pv is set at the wrap, the counter wraps to 0, D takes the value P, and pv is cleared in the same edge.
- **Disabled channel:** while en[i]=0, cnt is held at 0. If pv=1, P is applied on the next edge.
  - When en[i] rises, the first counted value is 0 in the cycle it is sampled high.
- **Outputs:** computed from cnt of the previous cycle.
  - tick[i] = en[i] && cnt==D-1.
  - clk_out[i] = en[i] && cnt >= floor(D/2).
  - Low phase is floor(D/2) cycles; high phase is ceil(D/2) cycles. Odd D gives a longer high phase by one cycle.
- **Valid write:** wr_en=1, wr_ch<NCH and wr_div>=2.
  - Loads P=wr_div and sets pv=1.
  - A second write before application overwrites P; the last write wins.
- **Rejected write:** wr_ch>=NCH, or wr_div<2 (0 or 1).
  - No state changes.
  - wr_err pulses high for one cycle, on the cycle after the write.
- **Sync:** on sync=1, every channel sets cnt=0.
  - Any pending P is applied and pv cleared.
  - A valid write in the same cycle as sync takes effect immediately as the new D.
  - Disabled channels remain held at 0.
- **Wrap and write in the same cycle:** if a write arrives in the cycle where cnt==D-1, the old P (if any) is applied at this wrap. The new value becomes pending for the next wrap.
- **Arithmetic:** all comparisons are unsigned and CW bits wide. D-1 is never negative because D>=2 always holds.

## Timing
- Output latency is one clk1 cycle from counter state.
- Output period is exactly D cycles while enabled, with no dropped or extra ticks across a divisor change.
- After a divisor change, the first period with the new D begins on the cycle after the last old-D tick.
- Reset is asynchronous assert and synchronous release. The first count occurs on the first edge with rst=0.
- Reset mid-period forces all outputs to 0 immediately, without waiting for a clock edge.
- en dropping mid-period: outputs go to 0 one cycle later, and the partial period is discarded.

## Test plan
Cases 1–5 override CW=8, NCH=2, CHW=1, DIV_INIT={8'd4,8'd5}.

1. **Reset release, both channels enabled:**
   - ch0: tick every 5 cycles; clk_out low 2 cycles, high 3.
   - ch1: tick every 4 cycles; clk_out low 2, high 2.
   - All outputs are 0 during reset.
2. **Mid-period divisor write:** write ch0 D=7 when cnt=1.
   - The current period completes at 5 cycles.
   - Subsequent ticks are 7 apart, with clk_out low 3, high 4.
3. **Invalid writes:** write D=1, D=0, and wr_ch=1 at NCH=1 build.
   - Each produces a wr_err pulse one cycle later.
   - Periods are unchanged.
4. **Two writes before the wrap:** write ch1 D=6 then D=3 before the wrap.
   - After the wrap the period is 3 (high 2, low 1).
   - The value 6 is never observed.
5. **en and sync:**
   - Drop en[1] for 10 cycles and re-raise it: outputs are 0 throughout, and the first tick comes 4 cycles after re-enable.
   - Pulse sync: both channels restart, and ticks realign at 5 and 4 cycles after sync.
6. **Default parameters:**
   - clk_out[0] period 50,000,000 cycles, clk_out[1] period 100,000 cycles.
   - Async rst asserted mid-period clears the outputs before the next edge.
